// File: rtl/fifty_stim_pkg.sv
// Shared types and constants for the FiftyModule stimulus sequencer.
// Lane arrays are packed so a whole step can be moved as one value.
package fifty_stim_pkg;

    localparam int DATA_W    = 17;
    localparam int NUM_LANES = 6;
    localparam int NUM_STEPS = 8;
    localparam int HOLD_W    = 8;
    localparam int STEP_W    = 3;
    localparam int LANE_W    = 3;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } seq_state_t;

    typedef logic [DATA_W-1:0] lane_t;
    typedef lane_t [NUM_LANES-1:0] lane_array_t;

    // A zero hold still shows its step for one cycle.
    function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_ONE : h;
    endfunction

endpackage

// File: rtl/fifty_stim_if.sv
// Configuration and run-control bus of the stimulus sequencer.
// master = controller or bench, slave = sequencer.
interface fifty_stim_if;
    import fifty_stim_pkg::*;

    logic                 cfg_we;
    logic [STEP_W-1:0]    cfg_step;
    logic [LANE_W-1:0]    cfg_lane;
    logic [DATA_W-1:0]    cfg_data;
    logic                 hold_we;
    logic [HOLD_W-1:0]    hold_data;
    logic                 start;
    logic                 loop;
    logic                 abort;
    logic [STEP_W-1:0]    step_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output cfg_we, cfg_step, cfg_lane, cfg_data, hold_we, hold_data,
        output start, loop, abort,
        input  step_idx, busy, done
    );

    modport slave (
        input  cfg_we, cfg_step, cfg_lane, cfg_data, hold_we, hold_data,
        input  start, loop, abort,
        output step_idx, busy, done
    );

endinterface

// File: rtl/fifty_stim_table.sv
// Pattern and hold storage for the stimulus sequencer.
// The read port forwards a same-cycle write so a run started together with a write sees it.
module fifty_stim_table
    import fifty_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [LANE_W-1:0] cfg_lane,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              hold_we,
    input  logic [HOLD_W-1:0] hold_data,
    input  logic [STEP_W-1:0] rd_step,
    output lane_array_t       rd_lanes,
    output logic [HOLD_W-1:0] rd_hold
);

    lane_array_t       pattern [NUM_STEPS];
    logic [HOLD_W-1:0] hold    [NUM_STEPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STEPS; s++) begin
                pattern[s] <= '0;
                hold[s]    <= HOLD_ONE;
            end
        end else begin
            if (wr_en && cfg_we) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (cfg_lane == LANE_W'(k)) begin
                        pattern[cfg_step][k] <= cfg_data;
                    end
                end
            end
            if (wr_en && hold_we) begin
                hold[cfg_step] <= hold_data;
            end
        end
    end

    always_comb begin
        rd_lanes = pattern[rd_step];
        rd_hold  = hold[rd_step];
        if (wr_en && cfg_we && (cfg_step == rd_step)) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (cfg_lane == LANE_W'(k)) begin
                    rd_lanes[k] = cfg_data;
                end
            end
        end
        if (wr_en && hold_we && (cfg_step == rd_step)) begin
            rd_hold = hold_data;
        end
    end

endmodule

// File: rtl/fifty_stim_sequencer.sv
// Programmable stimulus source for the FiftyModule inputs: steps through the pattern
// table, holding each step for its programmed number of cycles.
module fifty_stim_sequencer
    import fifty_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fifty_stim_if.slave       bus,
    output logic [DATA_W-1:0] stim_0,
    output logic [DATA_W-1:0] stim_1,
    output logic [DATA_W-1:0] stim_2,
    output logic [DATA_W-1:0] stim_3,
    output logic [DATA_W-1:0] stim_4,
    output logic [DATA_W-1:0] stim_5
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_nxt;
    logic [HOLD_W-1:0] count;
    logic [HOLD_W-1:0] count_nxt;
    lane_array_t       stim_q;
    lane_array_t       stim_nxt;
    logic              busy_q;
    logic              done_q;
    logic              load;
    logic              clear;
    logic              dec;
    lane_array_t       rd_lanes;
    logic [HOLD_W-1:0] rd_hold;

    fifty_stim_table u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (state == IDLE),
        .cfg_we    (bus.cfg_we),
        .cfg_step  (bus.cfg_step),
        .cfg_lane  (bus.cfg_lane),
        .cfg_data  (bus.cfg_data),
        .hold_we   (bus.hold_we),
        .hold_data (bus.hold_data),
        .rd_step   (step_nxt),
        .rd_lanes  (rd_lanes),
        .rd_hold   (rd_hold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step_q <= '0;
            count  <= '0;
            stim_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
            count  <= count_nxt;
            stim_q <= stim_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == FIN);
        end
    end

    // Abort outranks both the step advance and the loop wrap.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        load      = 1'b0;
        clear     = 1'b0;
        dec       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    clear     = 1'b1;
                end else if (count <= HOLD_ONE) begin
                    if (step_q != LAST_STEP) begin
                        step_nxt = step_q + STEP_W'(1);
                        load     = 1'b1;
                    end else if (bus.loop) begin
                        step_nxt = '0;
                        load     = 1'b1;
                    end else begin
                        state_nxt = FIN;
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        stim_nxt  = stim_q;
        count_nxt = count;
        if (load) begin
            stim_nxt  = rd_lanes;
            count_nxt = eff_hold(rd_hold);
        end else if (clear) begin
            stim_nxt = '0;
        end else if (dec) begin
            count_nxt = count - HOLD_ONE;
        end
    end

    assign bus.step_idx = step_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    assign stim_0 = stim_q[0];
    assign stim_1 = stim_q[1];
    assign stim_2 = stim_q[2];
    assign stim_3 = stim_q[3];
    assign stim_4 = stim_q[4];
    assign stim_5 = stim_q[5];

endmodule

// File: doc/fifty_stim_sequencer.md
Name: fifty_stim_sequencer

Overview:
- Synthesizable stimulus source sitting directly upstream of the M0 (FiftyModule) path-tracking design under test.
- Drives M0's six 17-bit data inputs from a programmable pattern table of NUM_STEPS steps.
- Each step is held for a programmable number of clock cycles.
- Replaces hand-written delay stimulus so PathMaker/DuRTL runs are repeatable, cycle-exact and reprogrammable without recompiling the bench.

Parameters:
- DATA_W, 17: width of each stim lane; matches the M0 input width.
- NUM_LANES, 6: number of stim outputs (in_0..in_5 of M0).
- NUM_STEPS, 8: pattern table depth.
- HOLD_W, 8: width of the per-step hold counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  pattern-table write strobe.
- cfg_step  in  3  table step index for the write.
- cfg_lane  in  3  lane index for the write; values 6 and 7 are ignored.
- cfg_data  in  DATA_W  pattern value to write.
- hold_we  in  1  hold-table write strobe; uses cfg_step as its index.
- hold_data  in  HOLD_W  hold length in cycles for step cfg_step.
- start  in  1  single-cycle request to begin a run.
- loop  in  1  sampled at the end of the last step; 1 = wrap to step 0.
- abort  in  1  synchronous run cancel.
- stim_0..stim_5  out  DATA_W each  lane outputs, wired to M0 in_0..in_5.
- step_idx  out  3  index of the step currently driven.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pattern table cleared to 0; hold table set to 1;
  - stim_* = 0, step_idx = 0, busy = 0, done = 0;
  - FSM forced to IDLE. This applies mid-run too: there is no resumption after reset.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - stim_* hold their last driven value, which is 0 after reset.
  - start=1 -> RUN next cycle: step_idx=0, stim_k=table[0][k], hold counter loaded with max(hold[0],1), busy=1.
  - Latency is one cycle from the start edge to the outputs changing.
- RUN:
  - The counter decrements each cycle.
  - When the counter equals 1 and step_idx < NUM_STEPS-1: next cycle step_idx+1, stim updated to that step's patterns, counter reloaded.
  - A step with hold h is therefore visible for exactly h cycles; h=0 is treated as 1.
- End of last step:
  - loop=1 -> wrap to step 0 and reload, with no done pulse.
  - loop=0 -> FIN.
- FIN: done=1 and busy=0 for exactly one cycle, stim_* keep the last step's value, then IDLE.
- abort=1 in RUN: next cycle IDLE, stim_*=0, step_idx=0, busy=0, no done pulse. abort has priority over step advance and over loop.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- Writes:
  - cfg_we and hold_we are accepted only when busy=0 and FSM is not FIN; otherwise dropped with no side effect.
  - A write in the same cycle as start is accepted. The run then uses the new value if it targets step 0.
  - Written values take effect the next cycle.
- Width: stim lanes are full DATA_W and never sign-extended or truncated. Hold arithmetic is unsigned and does not wrap because of the reload-at-1 rule.
- All outputs are registered; no combinational path from inputs to stim_*.

Decomposition:
- Shared package fifty_stim_pkg holds:
  - the state enum (IDLE/RUN/FIN);
  - constants DATA_W, NUM_LANES, NUM_STEPS, HOLD_W;
  - the lane-array typedef.
- One sub-module: fifty_stim_table, the pattern and hold storage with write decode and an asynchronous-read step port.
- FSM, counter and output registers live in fifty_stim_sequencer.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, release, no start -> all stim_*=0, busy=0, done=0 for 20 cycles.
2. Basic run:
   - Stimulus: program step0 all 0; step1 lanes 0x00FF,0x01FF,0x03FF,0x07FF,0x0FFF,0x1FFF; holds 2,4; other steps zero with hold 1; pulse start.
   - Required: step0 visible 2 cycles, step1 visible 4 cycles, steps 2..7 one cycle each, then done high 1 cycle; busy high for exactly 12 cycles.
3. Hold edge: hold[3]=0 -> step 3 visible 1 cycle. hold[3]=255 -> step 3 visible exactly 255 cycles.
4. Loop:
   - Stimulus: loop=1, all holds=1.
   - Required: step_idx sequence 0..7,0..7 with no done pulse. Dropping loop before step 7 ends -> single done pulse after step 7.
5. Abort and reset mid-run:
   - abort at step 4 -> next cycle stim_*=0, step_idx=0, busy=0, done never pulses.
   - rst_n low at step 5 -> outputs 0 immediately without waiting for clk; table reads back 0.
6. Write protection: during RUN write cfg_data=0x1FFFF to step 2 lane 0 -> ignored. Second run shows the original value; cfg_lane=6 write has no effect on any lane.
